// File: rtl/cube_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cube_pkg
// Purpose  : Shared defaults, scan state encoding and a sizing helper for the
//            LED cube row-scan sequencer and its BCM display timer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cube_pkg;

  localparam int unsigned DEFAULT_COLS       = 16;
  localparam int unsigned DEFAULT_ROWS       = 16;
  localparam int unsigned DEFAULT_PLANES     = 8;
  localparam int unsigned DEFAULT_BASE_TICKS = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_LATCH   = 2'd2,
    ST_DISPLAY = 2'd3
  } scan_state_e;

  // Width that holds the longest plane time (BASE_TICKS << (PLANES-1)).
  function automatic int unsigned bcm_cnt_width(input int unsigned base_ticks,
                                                input int unsigned planes);
    return $clog2((base_ticks << (planes - 1)) + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcm_timer.sv
`default_nettype none
// ============================================================================
// Module   : bcm_timer
// Purpose  : Binary-coded-modulation display countdown. A load pulse arms the
//            counter with BASE_TICKS << plane; done is high during the last
//            cycle of that display window.
// Ports    : clk, reset_n  - clock, async active-low reset
//            load          - arm the counter (cycle before the window starts)
//            plane         - bit plane selecting the window length
//            done          - last cycle of the display window
// Revision : 1.0 - initial release
// ============================================================================
module bcm_timer
  import cube_pkg::*;
#(
  parameter int unsigned PLANES     = DEFAULT_PLANES,
  parameter int unsigned BASE_TICKS = DEFAULT_BASE_TICKS
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic [$clog2(PLANES)-1:0] plane,
  output logic                      done
);

  localparam int unsigned CNT_W = bcm_cnt_width(BASE_TICKS, PLANES);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Counter parks at zero between windows so done cannot fire outside one.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = CNT_W'(BASE_TICKS) << plane;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/row_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : row_scan_sequencer
// Purpose  : Multiplexed LED cube scan engine. Per (row, plane) it shifts one
//            column word into the colour chains, latches it and lights the
//            row for a BCM-weighted time; swaps frame buffers at frame end.
// Ports    : clk, reset_n          - clock, async active-low reset
//            enable, swap_req      - scan enable, back-buffer-ready request
//            swap_ack, buffer_sel  - swap pulse, front buffer index
//            rd_en, row_idx, plane_idx, col_idx - framebuffer read address
//            serial_clk, latch_enable, output_enable_n, row_select_n - LED drive
//            frame_done            - pulse after the last plane of the last row
// Revision : 1.0 - initial release
// ============================================================================
module row_scan_sequencer
  import cube_pkg::*;
#(
  parameter int unsigned COLS       = DEFAULT_COLS,
  parameter int unsigned ROWS       = DEFAULT_ROWS,
  parameter int unsigned PLANES     = DEFAULT_PLANES,
  parameter int unsigned BASE_TICKS = DEFAULT_BASE_TICKS
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      swap_req,
  output logic                      swap_ack,
  output logic                      buffer_sel,
  output logic                      rd_en,
  output logic [$clog2(ROWS)-1:0]   row_idx,
  output logic [$clog2(PLANES)-1:0] plane_idx,
  output logic [$clog2(COLS)-1:0]   col_idx,
  output logic                      serial_clk,
  output logic                      latch_enable,
  output logic                      output_enable_n,
  output logic [ROWS-1:0]           row_select_n,
  output logic                      frame_done
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned PW = $clog2(PLANES);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned SW = $clog2(2 * COLS);

  localparam logic [SW-1:0] SHIFT_LAST = SW'(2 * COLS - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [PW-1:0] PLANE_LAST = PW'(PLANES - 1);

  scan_state_e   state_q, state_d;
  logic [SW-1:0] shift_cnt_q, shift_cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic [PW-1:0] plane_q, plane_d;
  logic          buffer_sel_q, buffer_sel_d;
  logic          frame_done_q, frame_done_d;
  logic          swap_ack_q, swap_ack_d;

  logic            rd_en_q, rd_en_d;
  logic            serial_clk_q, serial_clk_d;
  logic            latch_q, latch_d;
  logic            oe_n_q, oe_n_d;
  logic [CW-1:0]   col_q, col_d;
  logic [ROWS-1:0] row_sel_n_q, row_sel_n_d;

  logic timer_load;
  logic timer_done;

  // Arm the timer in LATCH so the count is ready on the first DISPLAY cycle.
  assign timer_load = (state_q == ST_LATCH);

  bcm_timer #(
    .PLANES    (PLANES),
    .BASE_TICKS(BASE_TICKS)
  ) u_bcm_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (timer_load),
    .plane  (plane_q),
    .done   (timer_done)
  );

  // State register (also holds scan indices and frame-level flags).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      shift_cnt_q  <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      buffer_sel_q <= 1'b0;
      frame_done_q <= 1'b0;
      swap_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_cnt_q  <= shift_cnt_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      buffer_sel_q <= buffer_sel_d;
      frame_done_q <= frame_done_d;
      swap_ack_q   <= swap_ack_d;
    end
  end

  // Next-state logic. Enable is only looked at in IDLE and at the end of a
  // display window, so a plane in progress always completes.
  always_comb begin
    state_d      = state_q;
    shift_cnt_d  = shift_cnt_q;
    row_d        = row_q;
    plane_d      = plane_q;
    buffer_sel_d = buffer_sel_q;
    frame_done_d = 1'b0;
    swap_ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d     = ST_SHIFT;
          shift_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (shift_cnt_q == SHIFT_LAST) begin
          state_d = ST_LATCH;
        end else begin
          shift_cnt_d = shift_cnt_q + SW'(1);
        end
      end
      ST_LATCH: begin
        state_d = ST_DISPLAY;
      end
      ST_DISPLAY: begin
        if (timer_done) begin
          shift_cnt_d = '0;
          state_d     = enable ? ST_SHIFT : ST_IDLE;
          if (plane_q == PLANE_LAST) begin
            plane_d = '0;
            if (row_q == ROW_LAST) begin
              // Frame boundary: the only point where the buffers may swap.
              row_d        = '0;
              frame_done_d = 1'b1;
              swap_ack_d   = swap_req;
              buffer_sel_d = buffer_sel_q ^ swap_req;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            plane_d = plane_q + PW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop that is
  // aligned with the state it describes.
  always_comb begin
    rd_en_d      = 1'b0;
    serial_clk_d = 1'b0;
    latch_d      = 1'b0;
    oe_n_d       = 1'b1;
    col_d        = '0;
    row_sel_n_d  = '1;
    case (state_d)
      ST_SHIFT: begin
        rd_en_d      = ~shift_cnt_d[0];
        serial_clk_d = shift_cnt_d[0];
        col_d        = CW'(shift_cnt_d >> 1);
      end
      ST_LATCH: begin
        latch_d = 1'b1;
      end
      ST_DISPLAY: begin
        oe_n_d             = 1'b0;
        row_sel_n_d[row_d] = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // Async reset blanks the LED drivers immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_en_q      <= 1'b0;
      serial_clk_q <= 1'b0;
      latch_q      <= 1'b0;
      oe_n_q       <= 1'b1;
      col_q        <= '0;
      row_sel_n_q  <= '1;
    end else begin
      rd_en_q      <= rd_en_d;
      serial_clk_q <= serial_clk_d;
      latch_q      <= latch_d;
      oe_n_q       <= oe_n_d;
      col_q        <= col_d;
      row_sel_n_q  <= row_sel_n_d;
    end
  end

  assign swap_ack        = swap_ack_q;
  assign buffer_sel      = buffer_sel_q;
  assign frame_done      = frame_done_q;
  assign row_idx         = row_q;
  assign plane_idx       = plane_q;
  assign col_idx         = col_q;
  assign rd_en           = rd_en_q;
  assign serial_clk      = serial_clk_q;
  assign latch_enable    = latch_q;
  assign output_enable_n = oe_n_q;
  assign row_select_n    = row_sel_n_q;

endmodule
`default_nettype wire

// File: tb/tb_row_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_row_scan_sequencer
// Purpose  : Self-checking bench for row_scan_sequencer. Stimulus queues the
//            expected display windows and frame boundaries; a negedge monitor
//            measures what the DUT does and compares against the queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_row_scan_sequencer;

  localparam int COLS       = 16;
  localparam int ROWS       = 16;
  localparam int PLANES     = 8;
  localparam int BASE_TICKS = 4;
  localparam int FRAME_CYC  = 20544;

  typedef struct {
    int row;
    int plane;
    int len;
  } disp_t;

  typedef struct {
    int gap;
    bit ack;
    bit bsel;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        swap_req;
  logic        swap_ack;
  logic        buffer_sel;
  logic        rd_en;
  logic [3:0]  row_idx;
  logic [2:0]  plane_idx;
  logic [3:0]  col_idx;
  logic        serial_clk;
  logic        latch_enable;
  logic        output_enable_n;
  logic [15:0] row_select_n;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_fd = 0;

  disp_t  disp_q[$];
  frame_t frame_q[$];

  row_scan_sequencer #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .PLANES    (PLANES),
    .BASE_TICKS(BASE_TICKS)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .swap_req       (swap_req),
    .swap_ack       (swap_ack),
    .buffer_sel     (buffer_sel),
    .rd_en          (rd_en),
    .row_idx        (row_idx),
    .plane_idx      (plane_idx),
    .col_idx        (col_idx),
    .serial_clk     (serial_clk),
    .latch_enable   (latch_enable),
    .output_enable_n(output_enable_n),
    .row_select_n   (row_select_n),
    .frame_done     (frame_done)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL timeout_%s: got no event expected event within bound (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitor ----------------
  int run_len = 0, run_row = 0, run_plane = 0;
  int rd_cnt = 0, sclk_cnt = 0, shift_start = 0, latch_cyc = 0;
  logic [15:0] exp_rs;

  always @(negedge clk) begin
    disp_t  de;
    frame_t fe;
    if (!reset_n) begin
      run_len  = 0;
      rd_cnt   = 0;
      sclk_cnt = 0;
    end else begin
      exp_rs = '1;
      if (!output_enable_n) exp_rs[row_idx] = 1'b0;
      chk("row_select_n", row_select_n, exp_rs);
      if (!output_enable_n) chk("latch_during_display", latch_enable, 1'b0);
      chk("swap_ack_outside_frame_done", swap_ack & ~frame_done, 1'b0);

      if (rd_en) begin
        if (rd_cnt == 0) shift_start = cyc;
        chk("col_idx", col_idx, rd_cnt);
        chk("sclk_with_rd_en", serial_clk, 1'b0);
        rd_cnt++;
      end
      if (serial_clk) sclk_cnt++;
      if (latch_enable) begin
        chk("sclk_pulses", sclk_cnt, COLS);
        chk("rd_strobes", rd_cnt, COLS);
        chk("shift_len", cyc - shift_start, 2 * COLS);
        chk("sclk_at_latch", serial_clk, 1'b0);
        latch_cyc = cyc;
        rd_cnt    = 0;
        sclk_cnt  = 0;
      end

      if (!output_enable_n) begin
        if (run_len == 0) begin
          run_row   = row_idx;
          run_plane = plane_idx;
          chk("latch_to_display", cyc - latch_cyc, 1);
        end
        run_len++;
      end else if (run_len > 0) begin
        if (disp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL display_unexpected: got row %0d plane %0d len %0d expected none", run_row, run_plane, run_len);
        end else begin
          de = disp_q.pop_front();
          chk("disp_row", run_row, de.row);
          chk("disp_plane", run_plane, de.plane);
          chk("disp_len", run_len, de.len);
        end
        run_len = 0;
      end

      if (frame_done) begin
        if (frame_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL frame_done_unexpected: got pulse expected none (cycle %0d)", cyc);
        end else begin
          fe = frame_q.pop_front();
          chk("frame_gap", cyc - last_fd, fe.gap);
          chk("frame_swap_ack", swap_ack, fe.ack);
          chk("frame_buffer_sel", buffer_sel, fe.bsel);
        end
        last_fd = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    reset_n  = 1'b0;
    enable   = 1'b0;
    swap_req = 1'b0;

    // Expected display windows: two full frames, then row 0 planes 0..5,
    // then after re-enable row 0 planes 6,7 and row 1 planes 0,1.
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < ROWS; r++)
        for (int p = 0; p < PLANES; p++)
          disp_q.push_back('{r, p, BASE_TICKS << p});
    for (int p = 0; p < 6; p++) disp_q.push_back('{0, p, BASE_TICKS << p});
    disp_q.push_back('{0, 6, 256});
    disp_q.push_back('{0, 7, 512});
    disp_q.push_back('{1, 0, 4});
    disp_q.push_back('{1, 1, 8});
    frame_q.push_back('{FRAME_CYC, 1'b1, 1'b1});
    frame_q.push_back('{FRAME_CYC, 1'b0, 1'b1});

    repeat (3) @(negedge clk);
    chk("rst_oe_n", output_enable_n, 1'b1);
    chk("rst_row_select_n", row_select_n, 16'hFFFF);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_serial_clk", serial_clk, 1'b0);
    chk("rst_latch", latch_enable, 1'b0);
    chk("rst_swap_ack", swap_ack, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_buffer_sel", buffer_sel, 1'b0);
    chk("rst_row_idx", row_idx, 4'd0);
    chk("rst_plane_idx", plane_idx, 3'd0);
    chk("rst_col_idx", col_idx, 4'd0);

    #2 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_rd_en", rd_en, 1'b0);
    chk("idle_oe_n", output_enable_n, 1'b1);

    // First SHIFT begins on the first edge with enable high.
    enable  = 1'b1;
    last_fd = cyc + 1;
    @(posedge clk);
    #1;
    chk("first_rd_en", rd_en, 1'b1);
    chk("first_col_idx", col_idx, 4'd0);
    chk("first_serial_clk", serial_clk, 1'b0);

    // Swap request raised mid-frame and held until acknowledged.
    repeat (5000) @(negedge clk);
    swap_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 25000 && !ok; i++) begin
      @(negedge clk);
      if (swap_ack) ok = 1'b1;
    end
    if (!ok) timeout("swap_ack");
    swap_req = 1'b0;

    ok = 1'b0;
    for (int i = 0; i < 22000 && !ok; i++) begin
      @(negedge clk);
      if (frame_done) ok = 1'b1;
    end
    if (!ok) timeout("frame_done_2");

    // Drop enable during the plane 5 shift of row 0.
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (plane_idx == 3'd5 && rd_en) ok = 1'b1;
    end
    if (!ok) timeout("plane5_shift");
    enable = 1'b0;
    repeat (300) @(negedge clk);
    chk("halt_oe_n", output_enable_n, 1'b1);
    chk("halt_rd_en", rd_en, 1'b0);
    chk("halt_plane_idx", plane_idx, 3'd6);
    chk("halt_row_idx", row_idx, 4'd0);
    chk("halt_pending_windows", disp_q.size(), 4);
    chk("halt_pending_frames", frame_q.size(), 0);

    // Resume at plane 6, stop again during row 1 plane 1 shift.
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (row_idx == 4'd1 && plane_idx == 3'd1 && rd_en) ok = 1'b1;
    end
    if (!ok) timeout("row1_plane1_shift");
    enable = 1'b0;
    repeat (200) @(negedge clk);
    chk("halt2_plane_idx", plane_idx, 3'd2);
    chk("halt2_row_idx", row_idx, 4'd1);
    chk("halt2_pending_windows", disp_q.size(), 0);

    // Reset pulsed during a display window blanks without a clock edge.
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!output_enable_n) ok = 1'b1;
    end
    if (!ok) timeout("display_for_reset");
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_oe_n", output_enable_n, 1'b1);
    chk("async_row_select_n", row_select_n, 16'hFFFF);
    chk("async_row_idx", row_idx, 4'd0);
    chk("async_plane_idx", plane_idx, 3'd0);
    chk("async_buffer_sel", buffer_sel, 1'b0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("final_pending_windows", disp_q.size(), 0);
    chk("final_pending_frames", frame_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/row_scan_sequencer.md
ROW_SCAN_SEQUENCER -- requirements
Module: row_scan_sequencer

Interface
REQ-001 Parameter COLS, default 16, shift-register bits per serial chain per row.
REQ-002 Parameter ROWS, default 16, number of multiplexed cube rows (layers).
REQ-003 Parameter PLANES, default 8, binary-coded-modulation (BCM) bit planes per colour.
REQ-004 Parameter BASE_TICKS, default 4, clk cycles of display time for bit plane 0.
REQ-005 clk  in  1  sole clock, 50 MHz; all state changes on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  level; 1 = scan frames, 0 = stop at next plane boundary.
REQ-008 swap_req  in  1  level from frame writer; back buffer complete, request swap.
REQ-009 swap_ack  out  1  one-cycle pulse; swap accepted at frame boundary.
REQ-010 buffer_sel  out  1  front (display) buffer index; toggles with swap_ack.
REQ-011 rd_en  out  1  framebuffer read strobe for current (row, plane, column).
REQ-012 row_idx  out  clog2(ROWS)  row being shifted/displayed.
REQ-013 plane_idx  out  clog2(PLANES)  current BCM bit plane.
REQ-014 col_idx  out  clog2(COLS)  column being shifted.
REQ-015 serial_clk  out  1  shift clock to all 12 colour chains.
REQ-016 latch_enable  out  1  transfers shift-register contents to outputs.
REQ-017 output_enable_n  out  1  active-low LED driver enable.
REQ-018 row_select_n  out  ROWS  one-cold row driver select.
REQ-019 frame_done  out  1  one-cycle pulse at end of last plane of last row.

Function
REQ-020 States SHALL be IDLE, SHIFT, LATCH, DISPLAY; IDLE->SHIFT when enable=1.
REQ-021 SHIFT SHALL last exactly 2*COLS cycles; cycle 2k: rd_en=1, col_idx=k, serial_clk=0; cycle 2k+1: rd_en=0, serial_clk=1.
REQ-022 SHIFT->LATCH after cycle 2*COLS-1; LATCH SHALL last 1 cycle with latch_enable=1, serial_clk=0.
REQ-023 LATCH->DISPLAY; DISPLAY SHALL last exactly BASE_TICKS<<plane_idx cycles with output_enable_n=0.
REQ-024 row_select_n SHALL be all ones except in DISPLAY, where bit row_idx alone is 0 (no ghosting across row changes).
REQ-025 output_enable_n SHALL be 1 in IDLE, SHIFT and LATCH.
REQ-026 End of DISPLAY: plane_idx increments; at PLANES-1 it wraps to 0 and row_idx increments; at ROWS-1 row_idx wraps to 0 and frame_done pulses on the following cycle.
REQ-027 End of DISPLAY: enable=1 -> SHIFT next cycle (no gap); enable=0 -> IDLE, indices retained; re-enable resumes at retained indices.
REQ-028 Frame swap SHALL occur only in the frame_done cycle: if swap_req=1 then, same cycle, swap_ack=1 and buffer_sel toggles; else no swap.
REQ-029 swap_req asserted mid-frame SHALL be held pending by the requester; no swap_ack before frame end.
REQ-030 Enable deasserted mid-SHIFT or mid-DISPLAY SHALL NOT truncate the current plane.
REQ-031 Display counter SHALL be wide enough for BASE_TICKS<<(PLANES-1) without overflow.

Reset
REQ-032 While reset_n=0: state IDLE; indices 0; buffer_sel 0; serial_clk, latch_enable, rd_en, swap_ack, frame_done 0; output_enable_n 1; row_select_n all ones.
REQ-033 Reset asserted mid-operation SHALL blank the LEDs (output_enable_n=1) asynchronously, without waiting for clk.
REQ-034 After reset release, first SHIFT starts on the first edge with enable=1.

Structure
REQ-035 COLS/ROWS/PLANES/BASE_TICKS defaults and the state enumeration SHALL live in shared package cube_pkg.
REQ-036 BCM display-time countdown SHALL be a sub-module bcm_timer (load BASE_TICKS<<plane, count, done pulse).
REQ-037 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-038 Reset, enable=1 -> first rd_en at cycle 0 of SHIFT, 16 serial_clk pulses, latch_enable after cycle 31, output_enable_n low 4 cycles.
REQ-039 Defaults, enable held -> 1284 cycles per row, 20544 cycles between frame_done pulses; DISPLAY lengths 4,8,...,512.
REQ-040 swap_req raised mid-frame -> single swap_ack coincident with frame_done, buffer_sel 0->1; swap_req low -> no ack.
REQ-041 enable dropped during plane 5 SHIFT -> plane 5 displays full 128 cycles, then IDLE; re-enable resumes at plane 6.
REQ-042 reset_n pulsed low during DISPLAY -> output_enable_n and row_select_n go high before next clk edge; indices 0.
REQ-043 Every cycle: output_enable_n=0 implies exactly one row_select_n bit low and latch_enable=0.
